// File: rtl/pyramid_scheduler.sv
// Read sequencer for an image pyramid: scans each octave of a ping-pong
// source buffer in raster order and streams pixels to a downsampler.
module pyramid_scheduler #(
    parameter int BIT_DEPTH    = 8,
    parameter int TOP_WIDTH    = 64,
    parameter int TOP_HEIGHT   = 64,
    parameter int NUM_OCTAVES  = 3,
    parameter int BRAM_LATENCY = 2,
    localparam int AW = $clog2(TOP_WIDTH * TOP_HEIGHT)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic [AW-1:0]        read_addr_out,
    output logic                 read_en_out,
    output logic                 read_bank_out,
    input  logic [BIT_DEPTH-1:0] read_data_in,
    output logic [BIT_DEPTH-1:0] pix_out,
    output logic [7:0]           pix_x_out,
    output logic [7:0]           pix_y_out,
    output logic                 pix_valid_out,
    output logic [1:0]           octave_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out
);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, NEXT, DONE} state_t;

    localparam logic [1:0] CNT_LAST = 2'(BRAM_LATENCY - 1);
    localparam logic [1:0] OCT_LAST = 2'(NUM_OCTAVES - 2);

    state_t          state_q, state_d;
    logic [7:0]      x_q, x_d, y_q, y_d;
    logic [1:0]      oct_q, oct_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [BRAM_LATENCY-1:0] vld_pipe_q;
    logic [7:0]              px_pipe_q [BRAM_LATENCY];
    logic [7:0]              py_pipe_q [BRAM_LATENCY];

    function automatic logic [8:0] dim(input int top, input logic [1:0] k);
        return 9'(top >> k);
    endfunction

    logic [8:0] w_cur, h_cur;
    logic       x_last, y_last;

    assign w_cur  = dim(TOP_WIDTH, oct_q);
    assign h_cur  = dim(TOP_HEIGHT, oct_q);
    assign x_last = ({1'b0, x_q} == w_cur - 9'd1);
    assign y_last = ({1'b0, y_q} == h_cur - 9'd1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        oct_d   = oct_q;
        cnt_d   = cnt_q;
        err_d   = start_in && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = FETCH;
                    oct_d   = 2'd0;
                    x_d     = 8'd0;
                    y_d     = 8'd0;
                end
            end
            FETCH: begin
                if (x_last) begin
                    x_d = 8'd0;
                    if (y_last) begin
                        state_d = DRAIN;
                        cnt_d   = 2'd0;
                    end else begin
                        y_d = y_q + 8'd1;
                    end
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_LAST) state_d = NEXT;
                else cnt_d = cnt_q + 2'd1;
            end
            NEXT: begin
                if (oct_q == OCT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                    oct_d   = oct_q + 2'd1;
                    x_d     = 8'd0;
                    y_d     = 8'd0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are registered against the state being entered
        en_d   = (state_d == FETCH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        addr_d = AW'(int'(y_d) * int'(dim(TOP_WIDTH, oct_d)) + int'(x_d));
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            oct_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            vld_pipe_q <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                px_pipe_q[i] <= '0;
                py_pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            oct_q   <= oct_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int i = BRAM_LATENCY - 1; i > 0; i--) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                px_pipe_q[i]  <= px_pipe_q[i-1];
                py_pipe_q[i]  <= py_pipe_q[i-1];
            end
            vld_pipe_q[0] <= en_q;
            px_pipe_q[0]  <= x_q;
            py_pipe_q[0]  <= y_q;
        end
    end

    assign read_addr_out = addr_q;
    assign read_en_out   = en_q;
    assign read_bank_out = oct_q[0];
    assign octave_out    = oct_q;
    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign error_out     = err_q;
    assign pix_valid_out = vld_pipe_q[BRAM_LATENCY-1];
    assign pix_x_out     = px_pipe_q[BRAM_LATENCY-1];
    assign pix_y_out     = py_pipe_q[BRAM_LATENCY-1];
    assign pix_out       = pix_valid_out ? read_data_in : '0;

endmodule

// File: tb/tb_pyramid_scheduler.sv
// Bench for pyramid_scheduler: three instances (latency 1, 2, 3) share the
// stimulus and are compared cycle by cycle against a per-cycle expectation table.
module tb_pyramid_scheduler;

    localparam int TW   = 8;
    localparam int TH   = 8;
    localparam int NO   = 3;
    localparam int MAXC = 100;

    typedef struct packed {
        logic       en;
        logic       vld;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] oct;
        logic [7:0] addr;
        logic [7:0] pix;
        logic [7:0] px;
        logic [7:0] py;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] addr  [3];
    logic       en    [3];
    logic       bank  [3];
    logic [7:0] rdata [3];
    logic [7:0] pix   [3];
    logic [7:0] px    [3];
    logic [7:0] py    [3];
    logic       vld   [3];
    logic [1:0] oct   [3];
    logic       busy  [3];
    logic       done  [3];
    logic       err   [3];

    logic [7:0] mem [64];
    exp_t       e [3][MAXC];
    int         done_c [3];
    int         nassert = 0;
    int         nfail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] bq [3];

        pyramid_scheduler #(
            .BIT_DEPTH   (8),
            .TOP_WIDTH   (TW),
            .TOP_HEIGHT  (TH),
            .NUM_OCTAVES (NO),
            .BRAM_LATENCY(g + 1)
        ) u_dut (
            .clk_in       (clk),
            .rst_in       (rst),
            .start_in     (start),
            .read_addr_out(addr[g]),
            .read_en_out  (en[g]),
            .read_bank_out(bank[g]),
            .read_data_in (rdata[g]),
            .pix_out      (pix[g]),
            .pix_x_out    (px[g]),
            .pix_y_out    (py[g]),
            .pix_valid_out(vld[g]),
            .octave_out   (oct[g]),
            .busy_out     (busy[g]),
            .done_out     (done[g]),
            .error_out    (err[g])
        );

        always @(posedge clk) begin
            bq[0] <= mem[addr[g]];
            bq[1] <= bq[0];
            bq[2] <= bq[1];
        end
        assign rdata[g] = bq[g];
    end

    task automatic chk(input string tag, input int i, input int c,
                       input logic [31:0] obs, input logic [31:0] exp_v);
        nassert++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s dut%0d cyc%0d: observed %0h expected %0h",
                   tag, i, c, obs, exp_v);
        end
    endtask

    task automatic build(input int err_at);
        for (int i = 0; i < 3; i++) begin
            int c, lat, w, h, ps;
            for (int j = 0; j < MAXC; j++) e[i][j] = '0;
            lat = i + 1;
            c = 0;
            for (int k = 0; k < NO - 1; k++) begin
                ps = c;
                w = TW >> k;
                h = TH >> k;
                for (int a = 0; a < w * h; a++) begin
                    e[i][c].en       = 1'b1;
                    e[i][c].addr     = 8'(a);
                    e[i][c+lat].vld  = 1'b1;
                    e[i][c+lat].pix  = mem[a];
                    e[i][c+lat].px   = 8'(a % w);
                    e[i][c+lat].py   = 8'(a / w);
                    c++;
                end
                c += lat + 1;
                for (int j = ps; j < c; j++) e[i][j].oct = 2'(k);
            end
            done_c[i] = c;
            e[i][c].done = 1'b1;
            for (int j = 0; j <= c; j++) e[i][j].busy = 1'b1;
            for (int j = c; j < MAXC; j++) e[i][j].oct = 2'(NO - 2);
            if (err_at >= 0) e[i][err_at+1].err = 1'b1;
        end
    endtask

    task automatic chk_cycle(input int c);
        for (int i = 0; i < 3; i++) begin
            chk("read_en", i, c, 32'(en[i]), 32'(e[i][c].en));
            chk("busy", i, c, 32'(busy[i]), 32'(e[i][c].busy));
            chk("done", i, c, 32'(done[i]), 32'(e[i][c].done));
            chk("error", i, c, 32'(err[i]), 32'(e[i][c].err));
            chk("valid", i, c, 32'(vld[i]), 32'(e[i][c].vld));
            chk("octave", i, c, 32'(oct[i]), 32'(e[i][c].oct));
            chk("bank", i, c, 32'(bank[i]), 32'(e[i][c].oct[0]));
            if (e[i][c].en)
                chk("addr", i, c, 32'(addr[i]), 32'(e[i][c].addr));
            if (e[i][c].vld) begin
                chk("pix", i, c, 32'(pix[i]), 32'(e[i][c].pix));
                chk("pix_x", i, c, 32'(px[i]), 32'(e[i][c].px));
                chk("pix_y", i, c, 32'(py[i]), 32'(e[i][c].py));
            end
        end
    endtask

    task automatic run(input int err_at, input int abort_at);
        int nc;
        int nb [3];
        int nv [3];
        nc = done_c[2] + 4;
        if (abort_at >= 0) nc = abort_at;
        for (int i = 0; i < 3; i++) begin
            nb[i] = 0;
            nv[i] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < nc; c++) begin
            start = (c == err_at);
            chk_cycle(c);
            for (int i = 0; i < 3; i++) begin
                nb[i] += int'(busy[i]);
                nv[i] += int'(vld[i]);
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (abort_at < 0) begin
            for (int i = 0; i < 3; i++) begin
                chk("busy_len", i, nc, 32'(nb[i]), 32'(done_c[i] + 1));
                chk("valid_cnt", i, nc, 32'(nv[i]), 32'(TW * TH + (TW * TH) / 4));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_addr"}, i, -1, 32'(addr[i]), 0);
            chk({tag, "_en"}, i, -1, 32'(en[i]), 0);
            chk({tag, "_bank"}, i, -1, 32'(bank[i]), 0);
            chk({tag, "_pix"}, i, -1, 32'(pix[i]), 0);
            chk({tag, "_px"}, i, -1, 32'(px[i]), 0);
            chk({tag, "_py"}, i, -1, 32'(py[i]), 0);
            chk({tag, "_valid"}, i, -1, 32'(vld[i]), 0);
            chk({tag, "_oct"}, i, -1, 32'(oct[i]), 0);
            chk({tag, "_busy"}, i, -1, 32'(busy[i]), 0);
            chk({tag, "_done"}, i, -1, 32'(done[i]), 0);
            chk({tag, "_err"}, i, -1, 32'(err[i]), 0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("idle_busy", i, k, 32'(busy[i]), 0);
                chk("idle_valid", i, k, 32'(vld[i]), 0);
                chk("idle_en", i, k, 32'(en[i]), 0);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        for (int j = 0; j < 64; j++) mem[j] = 8'(j);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        idle(3);

        build(-1);
        run(-1, -1);
        idle(int'($urandom_range(1, 5)));

        for (int j = 0; j < 64; j++) mem[j] = 8'($urandom);
        begin
            int ea;
            ea = int'($urandom_range(1, 60));
            build(ea);
            run(ea, -1);
        end
        idle(int'($urandom_range(1, 5)));

        build(0);
        run(0, -1);
        idle(3);

        build(-1);
        run(-1, 30);
        rst = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        chk_zero("abort_hold");
        rst = 1'b1;
        idle(4);

        for (int j = 0; j < 64; j++) mem[j] = 8'($urandom);
        build(-1);
        run(-1, -1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule
